edge_filter_en: RTL and testbench

- Multi-channel successor to the single-bit edge-to-enable block.
- Per channel:
  - Synchronises an asynchronous level input.
  - Rejects glitches with a stability counter.
  - Emits one-cycle rising/falling enables plus a mode-selected event strobe.
  - Keeps a sticky, software-clearable event flag.
- Sits between raw board inputs (buttons, strap pins, external sync lines) and the LED controller's control logic.

---
 rtl/edge_filter_pkg.sv | 6 +
 rtl/edge_filter_ch.sv | 69 ++++++
 rtl/edge_filter_en.sv | 45 ++++
 tb/tb_edge_filter_en.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/edge_filter_pkg.sv
// edge_filter_pkg: shared types and limits for the edge_filter_en channel bank
// Provides edge_mode_t (per-channel event qualification) and MAX_CH.
package edge_filter_pkg;
  typedef enum logic [1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_t;
  localparam int MAX_CH = 32;
endpackage

// File: rtl/edge_filter_ch.sv
// edge_filter_ch: one channel of synchroniser, glitch filter, edge pulses and sticky flag
// Ports: clk_in/rst_n_in clock and async active-low reset; edge_in raw async level;
//        mode_in event mode (edge_mode_t encoding); clr_in sticky flag clear;
//        level_out filtered level; rising_out/falling_out one-cycle edge pulses;
//        event_out mode-qualified pulse; flag_out sticky event flag.
module edge_filter_ch
  import edge_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W = $clog2(FILT_CYCLES + 1)
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       edge_in,
  input  logic [1:0] mode_in,
  input  logic       clr_in,
  output logic       level_out,
  output logic       rising_out,
  output logic       falling_out,
  output logic       event_out,
  output logic       flag_out
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic event_q, event_d, flag_q, flag_d;
  logic s, flip;
  edge_mode_t mode;
  always_comb begin
    mode = edge_mode_t'(mode_in);
    s = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], edge_in};
    // the level only flips after FILT_CYCLES consecutive disagreeing samples
    flip = (s != level_q) && (cnt_q == CNT_W'(FILT_CYCLES - 1));
    cnt_d = (s == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = flip ? s : level_q;
    rise_d = flip & s;
    fall_d = flip & ~s;
    event_d = (rise_d & (mode == EDGE_RISE || mode == EDGE_BOTH)) |
              (fall_d & (mode == EDGE_FALL || mode == EDGE_BOTH));
    // a pending set beats a coincident clear
    flag_d = event_q | (flag_q & ~clr_in);
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      event_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      event_q <= event_d;
      flag_q <= flag_d;
    end
  end
  assign level_out = level_q;
  assign rising_out = rise_q;
  assign falling_out = fall_q;
  assign event_out = event_q;
  assign flag_out = flag_q;
endmodule

// File: rtl/edge_filter_en.sv
// edge_filter_en: bank of CH independent filtered edge-to-enable channels
// Ports: clk_in/rst_n_in clock and async active-low reset; edge_in[CH] raw levels;
//        mode_in[2*CH] per-channel mode (bits 2k+1:2k for channel k); clr_in[CH] flag clears;
//        level_out, rising_out, falling_out, event_out, flag_out[CH] registered outputs.
module edge_filter_en
  import edge_filter_pkg::*;
#(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [CH-1:0]   edge_in,
  input  logic [2*CH-1:0] mode_in,
  input  logic [CH-1:0]   clr_in,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rising_out,
  output logic [CH-1:0]   falling_out,
  output logic [CH-1:0]   event_out,
  output logic [CH-1:0]   flag_out
);
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  if (CH < 1 || CH > MAX_CH) begin : g_bad_ch
    $error("edge_filter_en: CH out of range");
  end
  for (genvar k = 0; k < CH; k++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .edge_in(edge_in[k]),
      .mode_in(mode_in[2*k+1:2*k]),
      .clr_in(clr_in[k]),
      .level_out(level_out[k]),
      .rising_out(rising_out[k]),
      .falling_out(falling_out[k]),
      .event_out(event_out[k]),
      .flag_out(flag_out[k])
    );
  end
endmodule

// File: tb/tb_edge_filter_en.sv
// tb_edge_filter_en: directed scoreboard bench for edge_filter_en (default and fast-filter configs)
module tb_edge_filter_en;
  localparam int LVL = 0, RISE = 1, FALL = 2, EVT = 3, FLAG = 4, BL = 5, BR = 6, BF = 7;
  typedef struct {
    int at;
    int sel;
    logic [3:0] exp;
    string tag;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [3:0] edge_a = '0, clr_a = '0;
  logic [7:0] mode_a = '0;
  logic [3:0] level_a, rise_a, fall_a, event_a, flag_a;
  logic [1:0] edge_b = '0, clr_b = '0;
  logic [3:0] mode_b = '0;
  logic [1:0] level_b, rise_b, fall_b, event_b, flag_b;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  always #5 clk_in = ~clk_in;
  edge_filter_en #(.CH(4), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .edge_in(edge_a), .mode_in(mode_a), .clr_in(clr_a),
    .level_out(level_a), .rising_out(rise_a), .falling_out(fall_a), .event_out(event_a),
    .flag_out(flag_a)
  );
  edge_filter_en #(.CH(2), .SYNC_STAGES(3), .FILT_CYCLES(1)) u_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .edge_in(edge_b), .mode_in(mode_b), .clr_in(clr_b),
    .level_out(level_b), .rising_out(rise_b), .falling_out(fall_b), .event_out(event_b),
    .flag_out(flag_b)
  );
  function automatic logic [3:0] obs(int sel);
    case (sel)
      LVL: return level_a;
      RISE: return rise_a;
      FALL: return fall_a;
      EVT: return event_a;
      FLAG: return flag_a;
      BL: return {2'b00, level_b};
      BR: return {2'b00, rise_b};
      default: return {2'b00, fall_b};
    endcase
  endfunction
  task automatic check(string tag, logic [3:0] o, logic [3:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, o, e);
    end
  endtask
  task automatic push(int d, string tag, int sel, logic [3:0] e);
    sb.push_back('{cyc + d, sel, e, tag});
  endtask
  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      cyc++;
      for (int j = sb.size() - 1; j >= 0; j--)
        if (sb[j].at == cyc) begin
          check(sb[j].tag, obs(sb[j].sel), sb[j].exp);
          sb.delete(j);
        end
    end
  endtask
  initial begin
    logic v;
    #3;
    check("rst_level", level_a, 4'b0000);
    check("rst_pulses", rise_a | fall_a | event_a, 4'b0000);
    check("rst_flag", flag_a, 4'b0000);
    tick(2);
    rst_n_in = 1'b1;
    tick(2);
    // clean transition on channel 0
    edge_a[0] = 1'b1;
    push(5, "clean_l5", LVL, 4'b0000);
    push(5, "clean_r5", RISE, 4'b0000);
    push(6, "clean_l6", LVL, 4'b0001);
    push(6, "clean_r6", RISE, 4'b0001);
    push(6, "clean_f6", FALL, 4'b0000);
    push(6, "clean_e6", EVT, 4'b0000);
    push(7, "clean_r7", RISE, 4'b0000);
    push(7, "clean_l7", LVL, 4'b0001);
    tick(10);
    // 3-cycle glitch on channel 1 is swallowed
    edge_a[1] = 1'b1;
    for (int d = 1; d <= 9; d++) begin
      push(d, "glitch3_r", RISE, 4'b0000);
      push(d, "glitch3_f", FALL, 4'b0000);
      push(d, "glitch3_l", LVL, 4'b0001);
    end
    tick(3);
    edge_a[1] = 1'b0;
    tick(7);
    // 4-cycle pulse on channel 1 just qualifies
    edge_a[1] = 1'b1;
    push(5, "glitch4_r5", RISE, 4'b0000);
    push(6, "glitch4_r6", RISE, 4'b0010);
    push(6, "glitch4_l6", LVL, 4'b0011);
    push(7, "glitch4_r7", RISE, 4'b0000);
    tick(4);
    edge_a[1] = 1'b0;
    push(5, "glitch4_f5", FALL, 4'b0000);
    push(6, "glitch4_f6", FALL, 4'b0010);
    push(6, "glitch4_l10", LVL, 4'b0001);
    push(7, "glitch4_f7", FALL, 4'b0000);
    tick(10);
    // mode qualification: ch3 both, ch2 fall, ch1 rise, ch0 off
    mode_a = 8'b11_10_01_00;
    edge_a = 4'b0000;
    push(6, "mode_f0", FALL, 4'b0001);
    push(6, "mode_e0", EVT, 4'b0000);
    tick(8);
    edge_a = 4'b1111;
    push(6, "mode_rise", RISE, 4'b1111);
    push(6, "mode_erise", EVT, 4'b1010);
    push(7, "mode_erise7", EVT, 4'b0000);
    push(7, "mode_flag_r", FLAG, 4'b1010);
    tick(8);
    edge_a = 4'b0000;
    push(6, "mode_fall", FALL, 4'b1111);
    push(6, "mode_efall", EVT, 4'b1100);
    push(7, "mode_flag_f", FLAG, 4'b1110);
    tick(8);
    // sticky flag set, clear, and set-beats-clear
    clr_a = 4'b1111;
    tick(1);
    clr_a = 4'b0000;
    check("clr_all", flag_a, 4'b0000);
    edge_a[2] = 1'b1;
    push(6, "flag_rise_noevt", EVT, 4'b0000);
    push(7, "flag_rise_noflag", FLAG, 4'b0000);
    tick(8);
    edge_a[2] = 1'b0;
    push(6, "flag_evt", EVT, 4'b0100);
    push(7, "flag_set", FLAG, 4'b0100);
    tick(8);
    clr_a[2] = 1'b1;
    tick(1);
    clr_a[2] = 1'b0;
    check("flag_clr", flag_a, 4'b0000);
    edge_a[2] = 1'b1;
    tick(8);
    edge_a[2] = 1'b0;
    push(6, "coin_evt", EVT, 4'b0100);
    tick(6);
    clr_a[2] = 1'b1;
    tick(1);
    clr_a[2] = 1'b0;
    check("coin_flag", flag_a, 4'b0100);
    tick(1);
    check("coin_flag_hold", flag_a, 4'b0100);
    // asynchronous reset in the middle of a count
    edge_a[3] = 1'b1;
    tick(8);
    check("pre_rst_level", level_a, 4'b1000);
    edge_a[0] = 1'b1;
    tick(4);
    #1;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_level", level_a, 4'b0000);
    check("async_rst_flag", flag_a, 4'b0000);
    check("async_rst_pulses", rise_a | fall_a | event_a, 4'b0000);
    tick(2);
    rst_n_in = 1'b1;
    push(5, "rel_r5", RISE, 4'b0000);
    push(6, "rel_r6", RISE, 4'b1001);
    push(6, "rel_l6", LVL, 4'b1001);
    push(7, "rel_r7", RISE, 4'b0000);
    tick(8);
    // FILT_CYCLES=1, SYNC_STAGES=3: alternate every 2 cycles
    for (int k = 0; k < 6; k++) begin
      edge_b[0] = ~edge_b[0];
      v = edge_b[0];
      push(4, "fast_r", BR, {3'b000, v});
      push(4, "fast_f", BF, {3'b000, ~v});
      push(4, "fast_l", BL, {3'b000, v});
      push(5, "fast_r0", BR, 4'b0000);
      push(5, "fast_f0", BF, 4'b0000);
      tick(2);
    end
    tick(6);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
